fsm_rr_arb3: RTL

FSM_RR_ARB3 -- requirements
Module: fsm_rr_arb3

---
 rtl/fsm_rr_arb3.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/fsm_rr_arb3.sv
// fsm_rr_arb3 -- three-requester round-robin arbiter with a bounded hold time.
//
// The arbiter walks IDLE -> GRANT -> RELEASE. One requester owns the resource
// while in GRANT. The owner gives it up when its request drops, when done is
// raised, or when the hold counter reaches HOLD_MAX. RELEASE is a mandatory
// one-cycle dead gap between owners. After a release, the round-robin pointer
// moves to the requester just past the old owner, so the requester that was
// just served goes to the back of the queue.
//
// Handshake: there is no valid/ready pair. A requester raises req[i] and keeps
// it high for as long as it wants the resource. It owns the resource in every
// cycle where grant[i] is high. Lowering req[i] or raising done for one cycle
// releases the grant at the next rising edge. Requests from other requesters
// never disturb an active grant.
//
// Every output (grant, grant_id, busy, timeout) comes straight from a register,
// so none of them depends combinationally on req or done. state_o exposes the
// FSM state: 0 = IDLE, 1 = GRANT, 2 = RELEASE.

module fsm_rr_arb3 #(
  parameter int unsigned HOLD_MAX = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] req,
  input  logic       done,
  output logic [2:0] grant,
  output logic [1:0] grant_id,
  output logic       busy,
  output logic       timeout,
  output logic [1:0] state_o
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT   = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  localparam logic [7:0] HOLD_MAX_C = 8'(HOLD_MAX);

  state_t     state_q;
  logic [1:0] ptr_q;
  logic [1:0] owner_q;
  logic [7:0] cnt_q;
  logic [2:0] grant_q;
  logic [1:0] grant_id_q;
  logic       busy_q;
  logic       timeout_q;

  // Search candidates in priority order, and the winner of the search.
  logic [1:0] cand0;
  logic [1:0] cand1;
  logic [1:0] cand2;
  logic       pick_valid;
  logic [1:0] pick_idx;
  logic       owner_req;
  logic       hold_hit;
  logic       release_now;

  // Modulo-3 increment. The value 3 cannot occur here; it maps to 0 for safety.
  function automatic logic [1:0] inc3(input logic [1:0] x);
    return (x >= 2'd2) ? 2'd0 : x + 2'd1;
  endfunction

  // One-hot decode of a requester index. Index 3 gives zero.
  function automatic logic [2:0] to_onehot(input logic [1:0] i);
    logic [2:0] v;
    v = 3'b000;
    case (i)
      2'd0:    v = 3'b001;
      2'd1:    v = 3'b010;
      2'd2:    v = 3'b100;
      default: v = 3'b000;
    endcase
    return v;
  endfunction

  // Round-robin search: try ptr, then ptr+1, then ptr+2 (mod 3).
  always_comb begin
    cand0      = ptr_q;
    cand1      = inc3(ptr_q);
    cand2      = inc3(inc3(ptr_q));
    pick_valid = 1'b0;
    pick_idx   = 2'd0;
    // The candidates are tested lowest priority first, so the highest-priority
    // hit is written last and wins.
    if ((req & to_onehot(cand2)) != 3'b000) begin
      pick_valid = 1'b1;
      pick_idx   = cand2;
    end
    if ((req & to_onehot(cand1)) != 3'b000) begin
      pick_valid = 1'b1;
      pick_idx   = cand1;
    end
    if ((req & to_onehot(cand0)) != 3'b000) begin
      pick_valid = 1'b1;
      pick_idx   = cand0;
    end
  end

  // Release conditions for the current owner.
  always_comb begin
    owner_req   = (req & to_onehot(owner_q)) != 3'b000;
    hold_hit    = (cnt_q == HOLD_MAX_C);
    release_now = !owner_req || done || hold_hit;
  end

  // Arbiter FSM: state, pointer, hold counter and the registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ptr_q      <= 2'd0;
      owner_q    <= 2'd0;
      cnt_q      <= 8'd0;
      grant_q    <= 3'b000;
      grant_id_q <= 2'd0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        S_IDLE, S_RELEASE: begin
          if (pick_valid) begin
            state_q    <= S_GRANT;
            owner_q    <= pick_idx;
            cnt_q      <= 8'd1;
            grant_q    <= to_onehot(pick_idx);
            grant_id_q <= pick_idx;
            busy_q     <= 1'b1;
          end else begin
            state_q    <= S_IDLE;
            cnt_q      <= 8'd0;
            grant_q    <= 3'b000;
            grant_id_q <= 2'd0;
            busy_q     <= 1'b0;
          end
        end
        S_GRANT: begin
          if (release_now) begin
            state_q    <= S_RELEASE;
            ptr_q      <= inc3(owner_q);
            cnt_q      <= 8'd0;
            grant_q    <= 3'b000;
            grant_id_q <= 2'd0;
            busy_q     <= 1'b0;
            // Flag only a pure hold-limit release. A release that done or a
            // dropped request also caused at the same edge is not a timeout.
            timeout_q  <= hold_hit && owner_req && !done;
          end else if (cnt_q != HOLD_MAX_C) begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: begin
          state_q    <= S_IDLE;
          cnt_q      <= 8'd0;
          grant_q    <= 3'b000;
          grant_id_q <= 2'd0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign grant    = grant_q;
  assign grant_id = grant_id_q;
  assign busy     = busy_q;
  assign timeout  = timeout_q;
  assign state_o  = state_q;

endmodule
